exu_trap: RTL

- Machine-mode trap and interrupt controller.
- Drives the interrupt/return side of the execute-stage branch unit: produces int_ena, mtvec and mepc, and consumes mret.
- Owns mstatus, mie, mip, mtvec, mepc and mcause, and sequences interrupt entry and mret exit.
- Accessed by the CSR execute path through a val/rdy port; interrupts are taken only at an execute-stage instruction boundary.

---
 rtl/exu_trap.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/exu_trap.sv
// exu_trap: machine-mode trap and interrupt controller.
// Owns mstatus/mie/mip/mtvec/mepc/mcause, synchronizes the irq lines and
// sequences interrupt entry (IDLE -> PEND -> TRAP) and mret exit.
module exu_trap #(
   parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_irq_ext,
   input  logic        i_irq_sft,
   input  logic        i_irq_tmr,
   input  logic        i_inst_val,
   input  logic [31:0] i_inst_pc,
   input  logic        i_mret,
   output logic        o_int_ena,
   output logic [31:0] o_mtvec,
   output logic [31:0] o_mepc,
   input  logic        hs_ex4csr_val,
   output logic        hs_csr4ex_rdy,
   input  logic [11:0] i_csr_addr,
   input  logic        i_csr_wen,
   input  logic [31:0] i_csr_wdata,
   output logic [31:0] o_csr_rdata
);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   typedef enum logic [1:0] {IDLE, PEND, TRAP} state_t;

   // Synchronizer stages; within each stage [2]=ext, [1]=tmr, [0]=sft.
   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic                        mip_ext, mip_tmr, mip_sft;

   state_t      state;
   logic        mstatus_mie, mstatus_mpie;
   logic        mie_meie, mie_mtie, mie_msie;
   logic [31:2] mtvec_q, mepc_q;
   logic [31:0] mcause_q;

   logic [31:0] mstatus_val, mie_val, mip_val;
   logic        take, csr_wr;
   logic [3:0]  int_code;

   // The two low PC bits never reach mepc.
   logic        unused_pc;
   assign unused_pc = ^i_inst_pc[1:0];

   // Bring the asynchronous level irq lines into the clock domain.
   always_ff @(posedge clk) begin
      // NOTE: flops are written with <= so every stage samples the previous
      // stage's old value and the chain shifts by exactly one per edge.
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= {i_irq_ext, i_irq_tmr, i_irq_sft};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign {mip_ext, mip_tmr, mip_sft} = sync_q[SYNC_STAGES-1];

   assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
   assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 3'b0, mie_msie, 3'b0};
   assign mip_val     = {20'b0, mip_ext,  3'b0, mip_tmr,  3'b0, mip_sft,  3'b0};

   assign take   = mstatus_mie & (|(mip_val & mie_val));
   assign csr_wr = hs_ex4csr_val & i_csr_wen;

   // Entry fires only on a real instruction boundary that is neither an mret
   // nor a CSR access, so entry never races a CSR write.
   assign o_int_ena = (state == PEND) & take & i_inst_val & ~i_mret & ~hs_ex4csr_val;

   assign o_mtvec       = {mtvec_q, 2'b00};
   assign o_mepc        = {mepc_q, 2'b00};
   assign hs_csr4ex_rdy = 1'b1;

   // Pick the cause code of the highest-priority enabled pending interrupt.
   always_comb begin
      // NOTE: assigning a default first keeps this block purely combinational;
      // a path that left int_code unassigned would infer a latch.
      int_code = 4'd7;
      if (mip_ext & mie_meie) begin
         int_code = 4'd11;
      end else if (mip_sft & mie_msie) begin
         int_code = 4'd3;
      end
   end

   // CSR read mux; unmapped addresses read zero.
   always_comb begin
      o_csr_rdata = '0;
      case (i_csr_addr)
         CSR_MSTATUS: o_csr_rdata = mstatus_val;
         CSR_MIE:     o_csr_rdata = mie_val;
         CSR_MTVEC:   o_csr_rdata = o_mtvec;
         CSR_MEPC:    o_csr_rdata = o_mepc;
         CSR_MCAUSE:  o_csr_rdata = mcause_q;
         CSR_MIP:     o_csr_rdata = mip_val;
         default:     o_csr_rdata = '0;
      endcase
   end

   // Trap FSM plus CSR state; later assignments win, so mret overrides both
   // a same-cycle mstatus write and any state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_meie     <= 1'b0;
         mie_mtie     <= 1'b0;
         mie_msie     <= 1'b0;
         mtvec_q      <= MTVEC_RST[31:2];
         mepc_q       <= '0;
         mcause_q     <= '0;
      end else begin
         if (csr_wr) begin
            case (i_csr_addr)
               CSR_MSTATUS: begin
                  mstatus_mie  <= i_csr_wdata[3];
                  mstatus_mpie <= i_csr_wdata[7];
               end
               CSR_MIE: begin
                  mie_msie <= i_csr_wdata[3];
                  mie_mtie <= i_csr_wdata[7];
                  mie_meie <= i_csr_wdata[11];
               end
               CSR_MTVEC:  mtvec_q  <= i_csr_wdata[31:2];
               CSR_MEPC:   mepc_q   <= i_csr_wdata[31:2];
               CSR_MCAUSE: mcause_q <= i_csr_wdata;
               default: ;
            endcase
         end

         case (state)
            IDLE: begin
               if (take) state <= PEND;
            end
            PEND: begin
               if (o_int_ena) begin
                  mepc_q       <= i_inst_pc[31:2];
                  mcause_q     <= {1'b1, 27'b0, int_code};
                  mstatus_mpie <= mstatus_mie;
                  mstatus_mie  <= 1'b0;
                  state        <= TRAP;
               end else if (!take) begin
                  state <= IDLE;
               end
            end
            TRAP: ;
            default: state <= IDLE;
         endcase

         if (i_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            state        <= IDLE;
         end
      end
   end

endmodule
